// File: rtl/digital_lock.sv
// Four-key BCD combination lock with a multiplexed 7-segment display and an alarm
// tone streamed over a serial audio link; three wrong codes latch the alarm until reset.
module digital_lock #(
  parameter logic [15:0] PASSWORD  = 16'h1000,
  parameter int          MAX_TRIES = 3,
  parameter int          SCAN_DIV  = 50000,
  parameter int          TONE_DIV  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       key_c,
  input  logic       key_d,
  input  logic       Pause,
  output logic [6:0] postion_state,
  output logic [3:0] x,
  output logic [1:0] Led2,
  output logic [3:0] selector,
  output logic       dot,
  output logic       S_CLK,
  output logic       LR_CLK,
  output logic       M_CLK,
  output logic       Sin,
  output logic       clk2,
  output logic       clk3
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int TW = $clog2(TONE_DIV + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [7:0]    TRIES     = 8'(MAX_TRIES);

  typedef enum logic [1:0] {ENTRY = 2'd0, OPEN = 2'd1, ALARM = 2'd2} state_t;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  // key bit order {d, c, b, a}
  logic [3:0] sync1_r, sync2_r, prev_r, rise_s;
  state_t          state_r, state_n;
  logic [3:0][3:0] digit_r, digit_n;
  logic [1:0]      pos_r, pos_n;
  logic [7:0]      fail_r, fail_n;
  logic [15:0]     code_s;
  logic [SW-1:0]   scan_cnt_r;
  logic [1:0]      shown_pos_s;
  logic [8:0]      aud_cnt_r;
  logic [15:0]     shift_r, sample_s;
  logic [TW-1:0]   tone_cnt_r;

  assign rise_s = sync2_r & ~prev_r;
  assign code_s = {digit_r[0], digit_r[1], digit_r[2], digit_r[3]};

  // key synchronizers and edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      prev_r  <= 4'b0000;
    end else begin
      sync1_r <= {key_d, key_c, key_b, key_a};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // next-state logic; the if-chain order gives d > c > a > b priority
  always_comb begin
    state_n = state_r;
    digit_n = digit_r;
    pos_n   = pos_r;
    fail_n  = fail_r;
    case (state_r)
      ENTRY: begin
        if (rise_s[3]) begin
          if (code_s == PASSWORD) begin
            state_n = OPEN;
            fail_n  = 8'd0;
          end else begin
            fail_n  = fail_r + 8'd1;
            digit_n = 16'h0000;
            pos_n   = 2'd0;
            if (fail_n >= TRIES) state_n = ALARM;
            else state_n = ENTRY;
          end
        end else if (rise_s[2]) begin
          pos_n = pos_r + 2'd1;
        end else if (rise_s[0]) begin
          digit_n[pos_r] = (digit_r[pos_r] == 4'd9) ? 4'd0 : digit_r[pos_r] + 4'd1;
        end else if (rise_s[1]) begin
          digit_n[pos_r] = (digit_r[pos_r] == 4'd0) ? 4'd9 : digit_r[pos_r] - 4'd1;
        end else begin
          state_n = ENTRY;
        end
      end
      OPEN: begin
        if (rise_s[3]) begin
          state_n = ENTRY;
          digit_n = 16'h0000;
          pos_n   = 2'd0;
          fail_n  = 8'd0;
        end else begin
          state_n = OPEN;
        end
      end
      ALARM:   state_n = ALARM;
      default: state_n = ENTRY;
    endcase
  end

  // lock state and registered user-visible status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ENTRY;
      digit_r <= 16'h0000;
      pos_r   <= 2'd0;
      fail_r  <= 8'd0;
      Led2    <= 2'b00;
      x       <= 4'd0;
    end else begin
      state_r <= state_n;
      digit_r <= digit_n;
      pos_r   <= pos_n;
      fail_r  <= fail_n;
      Led2    <= (state_n == OPEN) ? 2'b01 : ((state_n == ALARM) ? 2'b10 : 2'b00);
      x       <= digit_n[pos_n];
    end
  end

  // display scan: rotate the active-low anode once per SCAN_DIV cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_r <= '0;
      selector   <= 4'b1110;
      clk2       <= 1'b0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      selector   <= {selector[2:0], selector[3]};
      clk2       <= ~clk2;
    end else begin
      scan_cnt_r <= scan_cnt_r + SW'(1);
    end
  end

  // segment and decimal-point decode; selector[3] is position 0
  always_comb begin
    case (selector)
      4'b0111: shown_pos_s = 2'd0;
      4'b1011: shown_pos_s = 2'd1;
      4'b1101: shown_pos_s = 2'd2;
      default: shown_pos_s = 2'd3;
    endcase
    if (state_r == ALARM) postion_state = 7'b0111111;
    else postion_state = seg_enc(digit_r[shown_pos_s]);
    if (shown_pos_s == pos_r) dot = 1'b0;
    else dot = 1'b1;
  end

  assign M_CLK  = aud_cnt_r[1];
  assign S_CLK  = aud_cnt_r[2];
  assign LR_CLK = aud_cnt_r[8];

  // alarm sample: +/-0x4000 square wave, silent when paused or not alarmed
  always_comb begin
    if (state_r == ALARM && !Pause) sample_s = clk3 ? 16'h4000 : 16'hC000;
    else sample_s = 16'h0000;
  end

  // serial audio: a new bit is loaded in the last cycle of each S_CLK high phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aud_cnt_r <= 9'd0;
      shift_r   <= 16'h0000;
      Sin       <= 1'b0;
    end else begin
      aud_cnt_r <= aud_cnt_r + 9'd1;
      if (aud_cnt_r[2:0] == 3'b111) begin
        if (aud_cnt_r[7:3] == 5'd31) begin
          Sin     <= sample_s[15];
          shift_r <= {sample_s[14:0], 1'b0};
        end else begin
          Sin     <= shift_r[15];
          shift_r <= {shift_r[14:0], 1'b0};
        end
      end
    end
  end

  // alarm tone: toggle every TONE_DIV LR frames while alarmed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_cnt_r <= '0;
      clk3       <= 1'b0;
    end else if (state_r != ALARM) begin
      tone_cnt_r <= '0;
      clk3       <= 1'b0;
    end else if (aud_cnt_r == 9'h1ff) begin
      if (tone_cnt_r == TONE_LAST) begin
        tone_cnt_r <= '0;
        clk3       <= ~clk3;
      end else begin
        tone_cnt_r <= tone_cnt_r + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_digital_lock.sv
// Self-checking bench for digital_lock: key presses feed a behavioural lock model
// whose expected (x, Led2) pairs are queued and compared against captured outputs.
module tb_digital_lock;
  logic clk = 1'b0;
  logic reset, key_a, key_b, key_c, key_d, Pause;
  logic [6:0] postion_state;
  logic [3:0] x, selector;
  logic [1:0] Led2;
  logic dot, S_CLK, LR_CLK, M_CLK, Sin, clk2, clk3;

  always #5 clk = ~clk;

  digital_lock #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .key_a(key_a), .key_b(key_b), .key_c(key_c),
    .key_d(key_d), .Pause(Pause), .postion_state(postion_state), .x(x),
    .Led2(Led2), .selector(selector), .dot(dot), .S_CLK(S_CLK),
    .LR_CLK(LR_CLK), .M_CLK(M_CLK), .Sin(Sin), .clk2(clk2), .clk3(clk3)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct { string tag; logic [3:0] x; logic [1:0] led; } snap_t;
  snap_t sb[$];
  snap_t obs[$];

  int m_dig[4];
  int m_pos, m_state, m_fail;   // m_state: 0 entry, 1 open, 2 alarm

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pos_of_sel(input logic [3:0] s);
    case (s)
      4'b0111: return 0;  4'b1011: return 1;  4'b1101: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_pos = 0;
  endfunction

  // mask bits {d, c, b, a}
  task automatic press(input logic [3:0] mask, input string tag, input int hold);
    logic [15:0] code;
    @(negedge clk);
    {key_d, key_c, key_b, key_a} = mask;
    repeat (hold) @(negedge clk);
    {key_d, key_c, key_b, key_a} = 4'b0000;
    repeat (4) @(negedge clk);
    if (m_state != 2) begin
      if (mask[3]) begin
        if (m_state == 0) begin
          code = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
          if (code == 16'h1000) begin
            m_state = 1; m_fail = 0;
          end else begin
            m_fail++; model_clear();
            if (m_fail >= 3) m_state = 2;
          end
        end else begin
          m_state = 0; m_fail = 0; model_clear();
        end
      end else if (m_state == 0) begin
        if (mask[2]) m_pos = (m_pos + 1) % 4;
        else if (mask[0]) m_dig[m_pos] = (m_dig[m_pos] == 9) ? 0 : m_dig[m_pos] + 1;
        else if (mask[1]) m_dig[m_pos] = (m_dig[m_pos] == 0) ? 9 : m_dig[m_pos] - 1;
      end
    end
    sb.push_back('{tag, 4'(m_dig[m_pos]),
                  (m_state == 1) ? 2'b01 : ((m_state == 2) ? 2'b10 : 2'b00)});
    obs.push_back('{tag, x, Led2});
  endtask

  task automatic capture_frame(output logic [15:0] word, output logic [15:0] tail,
                               output logic tone, output bit timeout);
    int n;
    logic prev_lr, prev_s;
    logic [31:0] bits;
    timeout = 1'b0; n = 0; bits = 32'h0;
    do begin prev_lr = LR_CLK; @(posedge clk); #1; n++; end
    while (!(prev_lr === 1'b0 && LR_CLK === 1'b1) && n < 1200);
    if (n >= 1200) timeout = 1'b1;
    tone = clk3;
    for (int i = 0; i < 32; i++) begin
      n = 0;
      do begin prev_s = S_CLK; @(posedge clk); #1; n++; end
      while (!(prev_s === 1'b0 && S_CLK === 1'b1) && n < 20);
      if (n >= 20) timeout = 1'b1;
      bits = {bits[30:0], Sin};
    end
    word = bits[31:16];
    tail = bits[15:0];
  endtask

  task automatic test_reset();
    logic [3:0] prev, want;
    int n;
    reset = 1'b1; {key_d, key_c, key_b, key_a} = 4'b0000; Pause = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (Led2 !== 2'b00 || x !== 4'd0 || selector !== 4'b1110 || postion_state !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_outputs: Led2=%b x=%0d sel=%b seg=%b, expected 00 0 1110 1000000",
               Led2, x, selector, postion_state);
    end
    tests_run++;
    if ({S_CLK, LR_CLK, M_CLK, Sin, clk2, clk3} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_clocks: got %b, expected 000000", {S_CLK, LR_CLK, M_CLK, Sin, clk2, clk3});
    end
    reset = 1'b0;
    m_state = 0; m_fail = 0; model_clear();
    prev = 4'b1110;
    for (int step = 0; step < 4; step++) begin
      n = 0;
      while (selector === prev && n < 20) begin @(posedge clk); #1; n++; end
      want = {prev[2:0], prev[3]};
      tests_run++;
      if (selector !== want || n != 4 || clk2 !== 1'((step + 1) % 2)) begin
        tests_failed++;
        $display("FAIL scan_step%0d: sel=%b after %0d cycles clk2=%b, expected %b after 4 clk2=%0d",
                 step, selector, n, clk2, want, (step + 1) % 2);
      end
      prev = want;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (Led2 !== 2'b00 || x !== 4'd0) begin
      tests_failed++;
      $display("FAIL idle: Led2=%b x=%0d, expected 00 0", Led2, x);
    end
  endtask

  task automatic test_enter_open();
    snap_t e, o;
    int sp;
    press(4'b0001, "a_held", 20);
    press(4'b0100, "c_pos1", 1);
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); tests_run++;
      if (o.x !== e.x || o.led !== e.led) begin
        tests_failed++;
        $display("FAIL %s: x=%0d Led2=%b, expected x=%0d Led2=%b", e.tag, o.x, o.led, e.x, e.led);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sp = pos_of_sel(selector);
      tests_run++;
      if (postion_state !== seg_of(m_dig[sp]) || dot !== ((sp == m_pos) ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL scan_entry: sel=%b seg=%b dot=%b, expected seg=%b dot=%b",
                 selector, postion_state, dot, seg_of(m_dig[sp]), (sp == m_pos) ? 1'b0 : 1'b1);
      end
    end
    @(negedge clk);
    key_d = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (Led2 !== 2'b00) begin
      tests_failed++;
      $display("FAIL open_early: Led2=%b after 2 edges, expected 00", Led2);
    end
    @(posedge clk); #1;
    tests_run++;
    if (Led2 !== 2'b01) begin
      tests_failed++;
      $display("FAIL open_latency: Led2=%b after 3 edges, expected 01", Led2);
    end
    @(negedge clk);
    key_d = 1'b0;
    m_state = 1; m_fail = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_open_relock();
    snap_t e, o;
    int sp;
    press(4'b0001, "open_a_ignored", 1);
    press(4'b1000, "open_relock", 1);
    for (int i = 0; i < 4; i++) press(4'b0100, "c_wrap", 1);
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); tests_run++;
      if (o.x !== e.x || o.led !== e.led) begin
        tests_failed++;
        $display("FAIL %s: x=%0d Led2=%b, expected x=%0d Led2=%b", e.tag, o.x, o.led, e.x, e.led);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sp = pos_of_sel(selector);
      tests_run++;
      if (dot !== ((selector == 4'b0111) ? 1'b0 : 1'b1) || postion_state !== seg_of(m_dig[sp])) begin
        tests_failed++;
        $display("FAIL dot_pos0: sel=%b dot=%b seg=%b, expected dot=%b seg=%b", selector, dot,
                 postion_state, (selector == 4'b0111) ? 1'b0 : 1'b1, seg_of(m_dig[sp]));
      end
    end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    for (int i = 0; i < 10; i++) press(4'b0001, "a_inc", 1);
    press(4'b0010, "b_wrap9", 1);
    press(4'b0001, "a_wrap0", 1);
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); tests_run++;
      if (o.x !== e.x || o.led !== e.led) begin
        tests_failed++;
        $display("FAIL %s: x=%0d Led2=%b, expected x=%0d Led2=%b", e.tag, o.x, o.led, e.x, e.led);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    press(4'b0101, "prio_c_over_a", 1);
    for (int i = 0; i < 3; i++) press(4'b0100, "c_back_to0", 1);
    press(4'b0011, "prio_a_over_b", 1);
    press(4'b1010, "prio_d_over_b", 1);
    press(4'b1000, "relock", 1);
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); tests_run++;
      if (o.x !== e.x || o.led !== e.led) begin
        tests_failed++;
        $display("FAIL %s: x=%0d Led2=%b, expected x=%0d Led2=%b", e.tag, o.x, o.led, e.x, e.led);
      end
    end
  endtask

  task automatic test_alarm();
    snap_t e, o;
    int n;
    logic prev;
    logic [15:0] word, tail;
    logic tone;
    bit tmo;
    press(4'b1000, "wrong1", 1);
    press(4'b0010, "b_to9", 1);
    press(4'b1000, "wrong2_clears", 1);
    press(4'b1000, "wrong3_alarm", 1);
    press(4'b0001, "alarm_a_ignored", 1);
    press(4'b1000, "alarm_d_ignored", 1);
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); tests_run++;
      if (o.x !== e.x || o.led !== e.led) begin
        tests_failed++;
        $display("FAIL %s: x=%0d Led2=%b, expected x=%0d Led2=%b", e.tag, o.x, o.led, e.x, e.led);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (postion_state !== 7'b0111111) begin
        tests_failed++;
        $display("FAIL alarm_dash: sel=%b seg=%b, expected 0111111", selector, postion_state);
      end
    end
    prev = clk3; n = 0;
    while (clk3 === prev && n < 5000) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n >= 5000) begin
      tests_failed++;
      $display("FAIL tone_start: clk3 stuck at %b, expected a toggle", clk3);
    end
    prev = clk3; n = 0;
    while (clk3 === prev && n < 5000) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n != 4096) begin
      tests_failed++;
      $display("FAIL tone_period: half-period %0d cycles, expected 4096", n);
    end
    for (int k = 0; k < 2; k++) begin
      capture_frame(word, tail, tone, tmo);
      tests_run++;
      if (tmo || word !== (tone ? 16'h4000 : 16'hC000) || tail !== 16'h0000) begin
        tests_failed++;
        $display("FAIL frame%0d: word=%h tail=%h timeout=%0d, expected %h tail 0000",
                 k, word, tail, tmo, tone ? 16'h4000 : 16'hC000);
      end
      prev = clk3; n = 0;
      while (clk3 === prev && n < 5000) begin @(posedge clk); #1; n++; end
    end
  endtask

  task automatic test_pause();
    int lr_edges, s_edges;
    logic lr_p, s_p, sin_seen;
    Pause = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    lr_edges = 0; s_edges = 0; sin_seen = 1'b0; lr_p = LR_CLK; s_p = S_CLK;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (LR_CLK !== lr_p) lr_edges++;
      if (S_CLK !== s_p) s_edges++;
      lr_p = LR_CLK; s_p = S_CLK;
      sin_seen = sin_seen | Sin;
    end
    tests_run++;
    if (sin_seen !== 1'b0 || lr_edges < 4 || s_edges < 200 || Led2 !== 2'b10) begin
      tests_failed++;
      $display("FAIL pause_mute: sin_seen=%b lr_edges=%0d s_edges=%0d Led2=%b, expected 0 >=4 >=200 10",
               sin_seen, lr_edges, s_edges, Led2);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (Led2 !== 2'b00 || clk3 !== 1'b0 || x !== 4'd0 || Sin !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_alarm: Led2=%b clk3=%b x=%0d Sin=%b, expected 00 0 0 0", Led2, clk3, x, Sin);
    end
    @(negedge clk);
    reset = 1'b0; Pause = 1'b0;
    m_state = 0; m_fail = 0; model_clear();
  endtask

  initial begin
    test_reset();
    test_enter_open();
    test_open_relock();
    test_wrap();
    test_back_to_back();
    test_alarm();
    test_pause();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
